serial_word_deserializer: RTL and testbench

Serial-to-parallel stage that sits directly downstream of the single-bit D flip-flop register stage. It consumes the registered bit stream one bit per accepted cycle and packs WIDTH bits into a word. It presents each word on a valid/ready output interface. A one-word output register lets the next word be collected while the previous one waits for the consumer.

---
 rtl/serial_word_deserializer.sv | 137 +++++++++++++
 tb/tb_serial_word_deserializer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_deserializer.sv
// Serial-to-parallel packer: collects WIDTH accepted bits into a word and
// presents it through a one-word valid/ready output register.
module serial_word_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             clear,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [CNT_W-1:0] word_count
);

    localparam int BC_W = $clog2(WIDTH + 1);
    localparam logic [BC_W-1:0] BC_ZERO = BC_W'(0);
    localparam logic [BC_W-1:0] BC_ONE  = BC_W'(1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(WIDTH - 1);
    localparam logic [BC_W-1:0] BC_FULL = BC_W'(WIDTH);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [BC_W-1:0]   bit_cnt_r, bit_cnt_nxt_s;
    logic [WIDTH-1:0]  shift_r, shift_nxt_s, shifted_s;
    logic [WIDTH-1:0]  dout_r, dout_nxt_s;
    logic              dout_valid_r, dout_valid_nxt_s;
    logic [CNT_W-1:0]  word_count_r, word_count_nxt_s;
    logic              free_s, accept_s, deliver_s;

    assign din_ready  = (state_r == ST_FILL);
    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign word_count = word_count_r;

    // Handshake qualifiers; a same-cycle drain frees the output register.
    always_comb begin
        free_s    = !dout_valid_r || dout_ready;
        accept_s  = din_valid && din_ready;
        deliver_s = dout_valid_r && dout_ready;
    end

    // Shifter image with the incoming bit inserted at the configured end.
    always_comb begin
        if (MSB_FIRST) begin
            shifted_s = {shift_r[WIDTH-2:0], din};
        end else begin
            shifted_s = {din, shift_r[WIDTH-1:1]};
        end
    end

    // Next-state and datapath update; clear outranks everything but reset.
    always_comb begin
        state_nxt_s      = state_r;
        bit_cnt_nxt_s    = bit_cnt_r;
        shift_nxt_s      = shift_r;
        dout_nxt_s       = dout_r;
        dout_valid_nxt_s = dout_valid_r;
        word_count_nxt_s = word_count_r;
        if (clear) begin
            state_nxt_s      = ST_FILL;
            bit_cnt_nxt_s    = BC_ZERO;
            dout_valid_nxt_s = 1'b0;
        end else begin
            if (deliver_s) begin
                word_count_nxt_s = word_count_r + CNT_W'(1);
                dout_valid_nxt_s = 1'b0;
            end else begin
                word_count_nxt_s = word_count_r;
            end
            case (state_r)
                ST_FILL: begin
                    if (accept_s) begin
                        shift_nxt_s = shifted_s;
                        if (bit_cnt_r == BC_LAST) begin
                            if (free_s) begin
                                dout_nxt_s       = shifted_s;
                                dout_valid_nxt_s = 1'b1;
                                bit_cnt_nxt_s    = BC_ZERO;
                            end else begin
                                bit_cnt_nxt_s = BC_FULL;
                                state_nxt_s   = ST_FULL;
                            end
                        end else begin
                            bit_cnt_nxt_s = bit_cnt_r + BC_ONE;
                        end
                    end else begin
                        shift_nxt_s = shift_r;
                    end
                end
                ST_FULL: begin
                    // Completed word parked in the shifter until the output frees.
                    if (free_s) begin
                        dout_nxt_s       = shift_r;
                        dout_valid_nxt_s = 1'b1;
                        bit_cnt_nxt_s    = BC_ZERO;
                        state_nxt_s      = ST_FILL;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                default: begin
                    state_nxt_s   = ST_FILL;
                    bit_cnt_nxt_s = BC_ZERO;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_FILL;
            bit_cnt_r    <= BC_ZERO;
            shift_r      <= {WIDTH{1'b0}};
            dout_r       <= {WIDTH{1'b0}};
            dout_valid_r <= 1'b0;
            word_count_r <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            bit_cnt_r    <= bit_cnt_nxt_s;
            shift_r      <= shift_nxt_s;
            dout_r       <= dout_nxt_s;
            dout_valid_r <= dout_valid_nxt_s;
            word_count_r <= word_count_nxt_s;
        end
    end

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Directed bench for serial_word_deserializer: MSB-first and LSB-first
// instances share one stimulus and are checked against a word-level model.
module tb_serial_word_deserializer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din = 1'b0, din_valid = 1'b0, clear = 1'b0, dout_ready = 1'b0;
    logic       rdy_m, rdy_l, dv_m, dv_l;
    logic [7:0] dout_m, dout_l, wc_m, wc_l;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_word_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1), .CNT_W(8)) dut_m (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_m),
        .clear(clear), .dout(dout_m), .dout_valid(dv_m), .dout_ready(dout_ready),
        .word_count(wc_m));

    serial_word_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0), .CNT_W(8)) dut_l (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_l),
        .clear(clear), .dout(dout_l), .dout_valid(dv_l), .dout_ready(dout_ready),
        .word_count(wc_l));

    // Model: bits collected so far, a parked word, and the output slot.
    bit         bq[$];
    bit         held_v, out_v;
    logic [7:0] held_m, held_l, out_m, out_l;
    int         delivered;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pack(input bit msb);
        logic [7:0] w;
        w = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (msb) w[7-i] = bq[i];
            else     w[i]   = bq[i];
        end
        return w;
    endfunction

    task automatic model_reset();
        bq.delete();
        held_v = 1'b0; out_v = 1'b0;
        held_m = 8'h00; held_l = 8'h00; out_m = 8'h00; out_l = 8'h00;
        delivered = 0;
    endtask

    always @(negedge rst) model_reset();

    always @(posedge clk) begin
        bit deliv, free, loaded;
        if (!rst) begin
            model_reset();
        end else if (clear) begin
            bq.delete();
            held_v = 1'b0;
            out_v  = 1'b0;
        end else begin
            deliv  = out_v && dout_ready;
            free   = !out_v || dout_ready;
            loaded = 1'b0;
            if (deliv) delivered++;
            if (held_v) begin
                if (free) begin
                    out_m = held_m; out_l = held_l;
                    held_v = 1'b0; loaded = 1'b1;
                end
            end else if (din_valid) begin
                bq.push_back(din);
                if (bq.size() == 8) begin
                    if (free) begin
                        out_m = pack(1'b1); out_l = pack(1'b0); loaded = 1'b1;
                    end else begin
                        held_m = pack(1'b1); held_l = pack(1'b0); held_v = 1'b1;
                    end
                    bq.delete();
                end
            end
            if (loaded) out_v = 1'b1;
            else if (deliv) out_v = 1'b0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("m_dout",  {24'h0, dout_m}, {24'h0, out_m});
            chk("l_dout",  {24'h0, dout_l}, {24'h0, out_l});
            chk("m_valid", {31'h0, dv_m},   {31'h0, out_v});
            chk("l_valid", {31'h0, dv_l},   {31'h0, out_v});
            chk("m_count", {24'h0, wc_m},   delivered % 256);
            chk("l_count", {24'h0, wc_l},   delivered % 256);
            chk("m_ready", {31'h0, rdy_m},  {31'h0, !held_v});
            chk("l_ready", {31'h0, rdy_l},  {31'h0, !held_v});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_bit(input logic b);
        din = b;
        din_valid = 1'b1;
        tick();
    endtask

    task automatic send(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) put_bit(w[i]);
        din_valid = 1'b0;
    endtask

    task automatic send_gap(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            put_bit(w[i]);
            din_valid = 1'b0;
            tick();
            tick();
        end
    endtask

    task automatic zero_check(input string tag);
        chk({tag, "_dout"},  {16'h0, dout_m, dout_l}, 32'h0);
        chk({tag, "_valid"}, {30'h0, dv_m, dv_l},     32'h0);
        chk({tag, "_count"}, {16'h0, wc_m, wc_l},     32'h0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        #1 zero_check("rst");
        @(posedge clk);
        #1 rst = 1'b1;
        clear = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
    endtask

    initial begin
        bit stream_ready_ok;
        model_reset();
        #12 rst = 1'b1;
        tick();

        // Single word, consumer ready.
        do_reset();
        chk("post_rst_ready", {30'h0, rdy_m, rdy_l}, 32'h3);
        dout_ready = 1'b1;
        send(8'hB2);
        chk("w1_m", {24'h0, dout_m}, 32'hB2);
        chk("w1_l", {24'h0, dout_l}, 32'h4D);
        chk("w1_valid", {31'h0, dv_m}, 32'h1);
        chk("w1_cnt0", {24'h0, wc_m}, 32'h0);
        tick();
        chk("w1_valid_fall", {31'h0, dv_m}, 32'h0);
        chk("w1_cnt1", {24'h0, wc_m}, 32'h1);
        chk("w1_hold", {24'h0, dout_m}, 32'hB2);

        // Backpressure: second word parks, one ready pulse swaps it in.
        do_reset();
        send(8'hB2);
        tick();
        chk("bp_a_hold", {24'h0, dout_m}, 32'hB2);
        send(8'h5C);
        chk("bp_full_rdy", {30'h0, rdy_m, rdy_l}, 32'h0);
        chk("bp_a_still", {24'h0, dout_m}, 32'hB2);
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        chk("bp_b_m", {24'h0, dout_m}, 32'h5C);
        chk("bp_b_l", {24'h0, dout_l}, 32'h3A);
        chk("bp_b_rdy", {31'h0, rdy_m}, 32'h1);
        chk("bp_cnt", {24'h0, wc_m}, 32'h1);
        dout_ready = 1'b1;
        tick();

        // Back-to-back streaming of three words.
        do_reset();
        dout_ready = 1'b1;
        stream_ready_ok = 1'b1;
        fork
            begin
                send(8'h12); send(8'h34); send(8'h56);
            end
            begin
                repeat (24) begin
                    @(negedge clk);
                    if (!rdy_m) stream_ready_ok = 1'b0;
                end
            end
        join
        tick();
        chk("st_ready_never0", {31'h0, stream_ready_ok}, 32'h1);
        chk("st_count", {24'h0, wc_m}, 32'h3);
        chk("st_last", {24'h0, dout_m}, 32'h56);

        // Gaps between bits leave the word unchanged.
        send_gap(8'h3C);
        chk("gap_m", {24'h0, dout_m}, 32'h3C);
        chk("gap_l", {24'h0, dout_l}, 32'h3C);
        tick();

        // Asynchronous reset in the middle of a word.
        do_reset();
        dout_ready = 1'b1;
        for (int i = 0; i < 5; i++) put_bit(1'b1);
        din_valid = 1'b0;
        #1 rst = 1'b0;
        #1 zero_check("mid_rst");
        #1 rst = 1'b1;
        tick();
        send(8'hA5);
        chk("mid_rst_m", {24'h0, dout_m}, 32'hA5);
        chk("mid_rst_l", {24'h0, dout_l}, 32'hA5);
        tick();

        // Clear while FULL with a word pending and consumer ready.
        do_reset();
        send(8'hB2);
        send(8'h5C);
        clear = 1'b1;
        dout_ready = 1'b1;
        tick();
        clear = 1'b0;
        dout_ready = 1'b0;
        chk("clr_valid", {31'h0, dv_m}, 32'h0);
        chk("clr_ready", {31'h0, rdy_m}, 32'h1);
        chk("clr_count", {24'h0, wc_m}, 32'h0);
        chk("clr_dout", {24'h0, dout_m}, 32'hB2);
        dout_ready = 1'b1;
        send(8'h69);
        chk("clr_fresh_m", {24'h0, dout_m}, 32'h69);
        chk("clr_fresh_l", {24'h0, dout_l}, 32'h96);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
